// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, datapath widths and the
// issue packet handed from operand fetch to execute.
package cpu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned CTRL_W     = 16;
    localparam int unsigned PC_W       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    typedef struct packed {
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        reg_idx_t          rd;
        logic              rd_we;
        logic [XLEN-1:0]   imm;
        logic [PC_W-1:0]   pc;
        logic [CTRL_W-1:0] ctrl;
    } issue_pkt_t;

    // One-hot select of a register; x0 never produces a bit.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t idx, input logic en);
        logic [NUM_REGS-1:0] v;
        v = '0;
        if (en && (idx != '0)) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 hard-wired clear.
// A set on the same cycle as a clear of the same register wins.
module operand_fetch_scoreboard
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en_i,
    input  reg_idx_t            set_idx_i,
    input  logic                clr_en_i,
    input  reg_idx_t            clr_idx_i,
    input  logic                fclr_en_i,
    input  reg_idx_t            fclr_idx_i,
    output logic [NUM_REGS-1:0] pending_o
);

    logic [NUM_REGS-1:0] pending_d, pending_q;

    always_comb begin
        pending_d = pending_q;
        pending_d = pending_d & ~reg_onehot(clr_idx_i, clr_en_i);
        pending_d = pending_d & ~reg_onehot(fclr_idx_i, fclr_en_i);
        pending_d = pending_d | reg_onehot(set_idx_i, set_en_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: hazard check against the pending scoreboard, operand select and a
// registered issue packet. OPERAND_FETCH_BYPASS_EN enables same-cycle writeback bypass.
module operand_fetch #(
    parameter int unsigned XLEN   = cpu_pkg::XLEN,
    parameter int unsigned CTRL_W = cpu_pkg::CTRL_W,
    parameter int unsigned PC_W   = cpu_pkg::PC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_we,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [4:0]        rf_rs1_addr,
    output logic [4:0]        rf_rs2_addr,
    input  logic [XLEN-1:0]   rf_rs1_data,
    input  logic [XLEN-1:0]   rf_rs2_data,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [4:0]        out_rd,
    output logic              out_rd_we,
    output logic [XLEN-1:0]   out_imm,
    output logic [PC_W-1:0]   out_pc,
    output logic [CTRL_W-1:0] out_ctrl
);
    import cpu_pkg::*;

    logic [NUM_REGS-1:0] pending;
    logic                wb_hit1, wb_hit2;
    logic                haz1, haz2, waw_haz, hazard;
    logic                load_ok, issue;
    logic [XLEN-1:0]     rs1_val, rs2_val;
    issue_pkt_t          out_d, out_q;
    logic                out_valid_d, out_valid_q;

    assign rf_rs1_addr = in_rs1;
    assign rf_rs2_addr = in_rs2;

    assign wb_hit1 = wb_we && (wb_rd == in_rs1) && (in_rs1 != '0);
    assign wb_hit2 = wb_we && (wb_rd == in_rs2) && (in_rs2 != '0);

`ifdef OPERAND_FETCH_BYPASS_EN
    logic wb_hit_rd;
    assign wb_hit_rd = wb_we && (wb_rd == in_rd) && (in_rd != '0);

    always_comb begin
        haz1    = pending[in_rs1] && !wb_hit1;
        haz2    = pending[in_rs2] && !wb_hit2;
        waw_haz = in_rd_we && (in_rd != '0) && pending[in_rd] && !wb_hit_rd;
        rs1_val = (in_rs1 == '0) ? '0 : (wb_hit1 ? wb_data : rf_rs1_data);
        rs2_val = (in_rs2 == '0) ? '0 : (wb_hit2 ? wb_data : rf_rs2_data);
    end
`else
    // Without bypass a same-cycle writeback still stalls until the RF holds the value.
    always_comb begin
        haz1    = pending[in_rs1] || wb_hit1;
        haz2    = pending[in_rs2] || wb_hit2;
        waw_haz = in_rd_we && (in_rd != '0) && pending[in_rd];
        rs1_val = (in_rs1 == '0) ? '0 : rf_rs1_data;
        rs2_val = (in_rs2 == '0) ? '0 : rf_rs2_data;
    end
`endif

    assign hazard   = haz1 || haz2 || waw_haz;
    assign load_ok  = !out_valid_q || out_ready;
    assign in_ready = load_ok && !hazard && !flush && !rst;
    assign issue    = in_valid && in_ready;

    operand_fetch_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (issue && in_rd_we),
        .set_idx_i  (in_rd),
        .clr_en_i   (wb_we),
        .clr_idx_i  (wb_rd),
        .fclr_en_i  (flush && out_valid_q && out_q.rd_we),
        .fclr_idx_i (out_q.rd),
        .pending_o  (pending)
    );

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (issue) begin
            out_d.rs1_val = rs1_val;
            out_d.rs2_val = rs2_val;
            out_d.rd      = in_rd;
            out_d.rd_we   = in_rd_we;
            out_d.imm     = in_imm;
            out_d.pc      = in_pc;
            out_d.ctrl    = in_ctrl;
            out_valid_d   = 1'b1;
        end else if (flush || out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Writeback data must be driven whenever the strobe is.
    a_wb_data_known: assert property (@(posedge clk) disable iff (rst)
        wb_we |-> !$isunknown(wb_data));

    assign out_valid   = out_valid_q;
    assign out_rs1_val = out_q.rs1_val;
    assign out_rs2_val = out_q.rs2_val;
    assign out_rd      = out_q.rd;
    assign out_rd_we   = out_q.rd_we;
    assign out_imm     = out_q.imm;
    assign out_pc      = out_q.pc;
    assign out_ctrl    = out_q.ctrl;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: a reference model predicts in_ready and issued
// packets; a separate monitor compares each presented packet against the expected queue.
module tb_operand_fetch;
    import cpu_pkg::*;

    logic        clk, rst, flush, in_valid, in_ready, in_rd_we, wb_we, out_valid, out_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd, rf_rs1_addr, rf_rs2_addr, wb_rd, out_rd;
    logic [31:0] in_imm, in_pc, rf_rs1_data, rf_rs2_data, wb_data;
    logic [31:0] out_rs1_val, out_rs2_val, out_imm, out_pc;
    logic [15:0] in_ctrl, out_ctrl;
    logic        out_rd_we;

    logic [31:0] regs [32];
    bit          mpend [32];
    bit          mv, mrd_we;
    logic [4:0]  mrd;
    logic [4:0]  inflight [$];
    issue_pkt_t  exp_q [$];
    int          n_checks = 0;
    int          n_fail = 0;

    assign rf_rs1_data = regs[rf_rs1_addr];
    assign rf_rs2_data = regs[rf_rs2_addr];

    operand_fetch dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .in_imm(in_imm), .in_pc(in_pc), .in_ctrl(in_ctrl),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_imm(out_imm), .out_pc(out_pc), .out_ctrl(out_ctrl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic bit hit(input bit wbe, input logic [4:0] wbr, input logic [4:0] r);
        return wbe && (wbr == r) && (r != 5'd0);
    endfunction

    // One cycle, entered at a negedge: drive, predict, check in_ready, advance the model.
    task automatic step(input bit v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input bit we, input bit fl, input bit ordy,
                        input bit wbe, input logic [4:0] wbr, input logic [31:0] wbd);
        bit h1, h2, waw, exp_rdy, iss, acc;
        issue_pkt_t p;
        in_valid = v; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_rd_we = we;
        in_imm = $urandom; in_pc = $urandom; in_ctrl = 16'($urandom);
        flush = fl; out_ready = ordy; wb_we = wbe; wb_rd = wbr; wb_data = wbd;
        #1;
`ifdef OPERAND_FETCH_BYPASS_EN
        h1  = mpend[r1] && !hit(wbe, wbr, r1);
        h2  = mpend[r2] && !hit(wbe, wbr, r2);
        waw = we && (rd != 5'd0) && mpend[rd] && !hit(wbe, wbr, rd);
`else
        h1  = mpend[r1] || hit(wbe, wbr, r1);
        h2  = mpend[r2] || hit(wbe, wbr, r2);
        waw = we && (rd != 5'd0) && mpend[rd];
`endif
        exp_rdy = (!mv || ordy) && !h1 && !h2 && !waw && !fl;
        check("in_ready", 256'(in_ready), 256'(exp_rdy));
        iss = v && exp_rdy;
        acc = mv && ordy && !fl;
        if (iss) begin
            p.rs1_val = (r1 == 5'd0) ? 32'd0 : regs[r1];
            p.rs2_val = (r2 == 5'd0) ? 32'd0 : regs[r2];
`ifdef OPERAND_FETCH_BYPASS_EN
            if (hit(wbe, wbr, r1)) p.rs1_val = wbd;
            if (hit(wbe, wbr, r2)) p.rs2_val = wbd;
`endif
            p.rd = rd; p.rd_we = we; p.imm = in_imm; p.pc = in_pc; p.ctrl = in_ctrl;
            exp_q.push_back(p);
        end
        @(posedge clk);
        #1;
        if (wbe && wbr != 5'd0) begin
            regs[wbr]  = wbd;
            mpend[wbr] = 1'b0;
            for (int i = 0; i < inflight.size(); i++) begin
                if (inflight[i] == wbr) begin
                    inflight.delete(i);
                    break;
                end
            end
        end
        if (fl && mv && mrd_we) mpend[mrd] = 1'b0;
        if (acc && mrd_we && mrd != 5'd0) inflight.push_back(mrd);
        if (iss && we && rd != 5'd0) mpend[rd] = 1'b1;
        if (iss) begin
            mv = 1'b1; mrd = rd; mrd_we = we;
        end else if (fl || ordy) begin
            mv = 1'b0;
        end
        @(negedge clk);
    endtask

    // Monitor: every presented packet must match the queue head; pop on accept or flush.
    initial begin
        issue_pkt_t g, e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_packet", 256'(out_valid), 256'(0));
                end else begin
                    e = exp_q[0];
                    g.rs1_val = out_rs1_val; g.rs2_val = out_rs2_val; g.rd = out_rd;
                    g.rd_we = out_rd_we; g.imm = out_imm; g.pc = out_pc; g.ctrl = out_ctrl;
                    check("packet", 256'(g), 256'(e));
                    if (out_ready || flush) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit wbe;
        logic [4:0] wbr;
        for (int i = 0; i < 32; i++) begin
            regs[i]  = (i == 0) ? 32'd0 : $urandom;
            mpend[i] = 1'b0;
        end
        mv = 1'b0; mrd = 5'd0; mrd_we = 1'b0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_rs1 = 5'd1; in_rs2 = 5'd2;
        in_rd = 5'd3; in_rd_we = 1'b1; in_imm = 32'h1234; in_pc = 32'h40; in_ctrl = 16'h5;
        out_ready = 1'b1; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 256'(in_ready), 256'(0));
        check("reset_out_valid", 256'(out_valid), 256'(0));
        check("reset_out_rd", 256'(out_rd), 256'(0));
        check("reset_out_rs1", 256'(out_rs1_val), 256'(0));
        check("reset_out_pc", 256'(out_pc), 256'(0));
        rst = 1'b0;

        // Independent ops back to back.
        step(1, 1, 2, 3, 1, 0, 1, 0, 0, 0);
        step(1, 5, 6, 4, 1, 0, 1, 0, 0, 0);
        // RAW: producer x5, three stalled cycles, then writeback of 0xDEADBEEF.
        step(1, 0, 0, 5, 1, 0, 1, 0, 0, 0);
        repeat (3) step(1, 5, 0, 8, 1, 0, 1, 0, 0, 0);
        step(1, 5, 0, 8, 1, 0, 1, 1, 5, 32'hDEADBEEF);
        step(1, 5, 0, 8, 1, 0, 1, 0, 0, 0);
        // Backpressure for four cycles, then release.
        step(1, 10, 11, 12, 1, 0, 0, 0, 0, 0);
        repeat (4) step(1, 1, 2, 14, 1, 0, 0, 0, 0, 0);
        step(1, 1, 2, 14, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        // Flush of a held x7 packet; x7 must be free afterwards.
        step(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 13, 1, 1, 0, 0, 0, 0);
        step(1, 7, 0, 0, 0, 0, 1, 0, 0, 0);
        // x0 destination and source.
        step(1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        // Set/clear collision on x9, then a consumer of x9 must stall.
        step(1, 0, 0, 9, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 9, 1, 0, 1, 1, 9, 32'h9999);
        step(1, 9, 0, 0, 0, 0, 1, 0, 0, 0);

        for (int c = 0; c < 3000; c++) begin
            wbe = 1'b0; wbr = 5'd0;
            if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
                wbe = 1'b1;
                wbr = inflight[$urandom_range(0, inflight.size() - 1)];
            end else if ($urandom_range(0, 15) == 0) begin
                wbe = 1'b1;
            end
            step(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 15)),
                 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 1'($urandom),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 wbe, wbr, $urandom);
        end

        // Drain: retire everything still in flight.
        for (int c = 0; c < 60; c++) begin
            wbe = 1'b0; wbr = 5'd0;
            if (inflight.size() > 0) begin
                wbe = 1'b1;
                wbr = inflight[0];
            end
            step(0, 0, 0, 0, 0, 0, 1, wbe, wbr, $urandom);
        end
        check("queue_drained", 256'(exp_q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue stage between decode and execute.
- Accepts one decoded instruction per cycle over valid/ready and drives the source addresses to the register file's asynchronous read ports.
- Selects operand values, with writeback bypass, and tracks in-flight destination registers in a 32-bit scoreboard to stall on RAW/WAW hazards.
- Presents a registered issue packet to execute over valid/ready.

Parameters:
- XLEN, 32, operand/data width
- CTRL_W, 16, width of opaque control bundle passed through to execute
- PC_W, 32, program counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard output packet and current input; pipeline redirect
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1  in  5  source register 1 index
- in_rs2  in  5  source register 2 index
- in_rd  in  5  destination index
- in_rd_we  in  1  instruction writes rd
- in_imm  in  XLEN  immediate, passed through
- in_pc  in  PC_W  instruction PC, passed through
- in_ctrl  in  CTRL_W  control bundle, passed through
- rf_rs1_addr  out  5  register file read address 1 (= in_rs1, combinational)
- rf_rs2_addr  out  5  register file read address 2 (= in_rs2, combinational)
- rf_rs1_data  in  XLEN  register file read data 1 (asynchronous read, x0 reads 0)
- rf_rs2_data  in  XLEN  register file read data 2
- wb_we  in  1  writeback strobe; same signal that drives the register file write port
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback data
- out_valid  out  1  issue packet valid
- out_ready  in  1  execute accepts packet
- out_rs1_val, out_rs2_val  out  XLEN  resolved operands
- out_rd, out_rd_we, out_imm, out_pc, out_ctrl  out  as inputs  registered pass-through fields

Behaviour:
- Reset: out_valid=0, scoreboard pending[31:0]=0, all out_* data fields=0. in_ready is combinational and is 0 while rst=1.
- wb_hit(r): wb_we && wb_rd==r && r!=0.
- Hazard:
  - src_haz(r) = pending[r] && !wb_hit(r), for r in {in_rs1, in_rs2}.
  - waw_haz = in_rd_we && in_rd!=0 && pending[in_rd] && !wb_hit(in_rd).
  - x0 is never pending.
- Output stage can load: load_ok = !out_valid || out_ready.
- in_ready = load_ok && !hazard && !flush && !rst.
- Issue occurs when in_valid && in_ready.
- Operand select: wb_hit(rs) ? wb_data : rf_rsN_data; rs==0 yields 0.
- Latency: one cycle. An instruction issued in cycle N appears on out_* with out_valid=1 in cycle N+1.
- Output register:
  - On issue, load all fields and set out_valid=1.
  - Else, if out_ready, set out_valid=0.
  - Else hold all fields stable.
- Scoreboard:
  - Issue with in_rd_we && in_rd!=0 sets pending[in_rd].
  - wb_hit clears pending[wb_rd].
  - Same register set and cleared in the same cycle: set wins.
- Flush:
  - Clears out_valid.
  - Clears pending[out_rd] if the discarded packet had out_rd_we.
  - Blocks issue that cycle.
  - Older in-flight instructions beyond execute still write back and clear their own bits.
- Flush together with wb_hit on the same register: the register ends cleared.
- Writes to x0 are ignored by the scoreboard.

Optional Feature:
- Macro: OPERAND_FETCH_BYPASS_EN.
- Defined: wb bypass as above; a same-cycle writeback resolves the hazard with zero stall.
- Undefined:
  - Operands always come from rf_rsN_data.
  - wb_hit no longer masks hazards: src_haz(r) = pending[r] || wb_hit(r).
  - Consumer stalls exactly one extra cycle until the register file holds the value.
  - Scoreboard update is unchanged.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN
  - REG_ADDR_W=5
  - typedef issue_pkt_t: rs1_val, rs2_val, rd, rd_we, imm, pc, ctrl
- Sub-module: scoreboard (32-bit pending vector).
  - Inputs: set strobe/index, clear strobe/index, flush-clear strobe/index.
  - Outputs: pending vector.
  - Set-over-clear priority lives inside it.

Test Plan:
- Independent ops: issue add x3,x1,x2 then add x4,x5,x6 back-to-back with out_ready=1 -> in_ready stays 1, two consecutive out_valid cycles, pending[3] and pending[4] set.
- RAW stall: issue rd=x5, hold wb off 3 cycles, present rs1=x5 -> in_ready=0 for 3 cycles. Then wb_we=1, wb_rd=5, wb_data=0xDEADBEEF -> issue same cycle with out_rs1_val=0xDEADBEEF (bypass) or one cycle later (bypass disabled).
- Backpressure: out_ready=0 for 4 cycles with out_valid=1 -> out_* fields constant, in_ready=0. Release -> next packet follows on the following cycle.
- Flush: packet rd=x7 in output register, assert flush -> out_valid=0 next cycle, pending[7]=0, no issue that cycle.
- x0 handling: issue rd_we=1, rd=0, then rs1=0 -> no stall, out_rs1_val=0, pending stays 0.
- Set/clear collision: wb_rd=9 while issuing rd=9 in the same cycle -> pending[9]=1 afterwards.
